// File: rtl/snake_motion_ctrl.sv
// Snake head motion controller: IDLE/RUN/DEAD game FSM, frame-paced stepping,
// player-1 direction handling and wall-collision detection.
module snake_motion_ctrl #(
    parameter int SNAKE_SIZE  = 16,
    parameter int SNAKE_SPEED = 5,
    parameter int SCREEN_W    = 256,
    parameter int SCREEN_H    = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic [7:0] switches_p1,
    output logic [8:0] snake_x,
    output logic [8:0] snake_y,
    output logic [1:0] dir,
    output logic [1:0] game_state,
    output logic       step,
    output logic       crashed
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam int CW = (SNAKE_SPEED > 1) ? $clog2(SNAKE_SPEED) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SNAKE_SPEED - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [8:0] X_HOME = 9'(SCREEN_W / 2 - SNAKE_SIZE / 2);
    localparam logic [8:0] Y_HOME = 9'(SCREEN_H / 2 - SNAKE_SIZE / 2);
    localparam logic signed [9:0] X_MAX   = 10'(SCREEN_W - SNAKE_SIZE);
    localparam logic signed [9:0] Y_MAX   = 10'(SCREEN_H - SNAKE_SIZE);
    localparam logic signed [9:0] STEP_PX = 10'(SNAKE_SIZE);

    state_t        state_q, state_d;
    logic [8:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    next_dir_q, next_dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          crashed_q, crashed_d;
    logic          start_q;

    logic              start_edge_s;
    logic [2:0]        req_s;
    logic [1:0]        ref_dir_s;
    logic signed [9:0] next_x_s;
    logic signed [9:0] next_y_s;
    logic              out_of_bounds_s;
    logic              unused_sw_s;

    assign unused_sw_s = ^switches_p1[7:5];

    // Returns {valid, direction}; lowest pressed switch wins (left > right > up > down).
    function automatic logic [2:0] decode_req(input logic [3:0] sw);
        logic [2:0] r;
        if (sw[0]) begin
            r = {1'b1, DIR_LEFT};
        end else if (sw[1]) begin
            r = {1'b1, DIR_RIGHT};
        end else if (sw[2]) begin
            r = {1'b1, DIR_UP};
        end else if (sw[3]) begin
            r = {1'b1, DIR_DOWN};
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Candidate head position for the pending direction and its wall check.
    always_comb begin
        next_x_s = $signed({1'b0, x_q});
        next_y_s = $signed({1'b0, y_q});
        case (next_dir_q)
            DIR_RIGHT: next_x_s = $signed({1'b0, x_q}) + STEP_PX;
            DIR_LEFT:  next_x_s = $signed({1'b0, x_q}) - STEP_PX;
            DIR_UP:    next_y_s = $signed({1'b0, y_q}) - STEP_PX;
            DIR_DOWN:  next_y_s = $signed({1'b0, y_q}) + STEP_PX;
            default:   next_x_s = $signed({1'b0, x_q});
        endcase
        out_of_bounds_s = (next_x_s > X_MAX) || (next_x_s < 10'sd0) ||
                          (next_y_s > Y_MAX) || (next_y_s < 10'sd0);
    end

    // Game FSM next-state, pacing and direction-request logic.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;
        next_dir_d   = next_dir_q;
        cnt_d        = cnt_q;
        step_d       = 1'b0;
        ref_dir_s    = dir_q;
        start_edge_s = switches_p1[4] & ~start_q;
        req_s        = decode_req(switches_p1[3:0]);

        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d    = ST_RUN;
                    cnt_d      = CNT_ZERO;
                    next_dir_d = dir_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (out_of_bounds_s) begin
                            state_d = ST_DEAD;
                        end else begin
                            x_d       = next_x_s[8:0];
                            y_d       = next_y_s[8:0];
                            dir_d     = next_dir_q;
                            step_d    = 1'b1;
                            ref_dir_s = next_dir_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                // A request landing on the step cycle is judged against the direction being committed.
                if (req_s[2] && (state_d == ST_RUN) && (req_s[1:0] != ref_dir_s) &&
                    (req_s[1:0] != (ref_dir_s ^ 2'b01))) begin
                    next_dir_d = req_s[1:0];
                end else begin
                    next_dir_d = next_dir_q;
                end
            end
            ST_DEAD: begin
                if (start_edge_s) begin
                    state_d    = ST_IDLE;
                    x_d        = X_HOME;
                    y_d        = Y_HOME;
                    dir_d      = DIR_RIGHT;
                    next_dir_d = DIR_RIGHT;
                    cnt_d      = CNT_ZERO;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        crashed_d = (state_d == ST_DEAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x_q        <= X_HOME;
            y_q        <= Y_HOME;
            dir_q      <= DIR_RIGHT;
            next_dir_q <= DIR_RIGHT;
            cnt_q      <= CNT_ZERO;
            step_q     <= 1'b0;
            crashed_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            next_dir_q <= next_dir_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            crashed_q  <= crashed_d;
            start_q    <= switches_p1[4];
        end
    end

    assign snake_x    = x_q;
    assign snake_y    = y_q;
    assign dir        = dir_q;
    assign game_state = state_q;
    assign step       = step_q;
    assign crashed    = crashed_q;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Directed bench for snake_motion_ctrl; step pulses are checked against a
// scoreboard of expected head positions pushed as each step is provoked.
module tb_snake_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame = 1'b0;
    logic [7:0] switches_p1 = 8'h00;
    logic [8:0] snake_x, snake_y;
    logic [1:0] dir, game_state;
    logic       step, crashed;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [1:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail = 0;
    int   n_steps = 0;
    int   steps_before;

    snake_motion_ctrl dut (
        .clk(clk), .reset(reset), .frame(frame), .switches_p1(switches_p1),
        .snake_x(snake_x), .snake_y(snake_y), .dir(dir),
        .game_state(game_state), .step(step), .crashed(crashed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            tick(1);
            frame = 1'b0;
            tick(3);
        end
    endtask

    task automatic press(input logic [7:0] val);
        switches_p1 = val;
        tick(1);
        switches_p1 = 8'h00;
        tick(1);
    endtask

    task automatic push(input int x, input int y, input int d);
        exp_t e;
        e.x = 9'(x);
        e.y = 9'(y);
        e.d = 2'(d);
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every step pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (step) begin
            n_steps++;
            if (sb.size() == 0) begin
                check("unexpected_step", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_x", int'(snake_x), int'(e.x));
                check("step_y", int'(snake_y), int'(e.y));
                check("step_dir", int'(dir), int'(e.d));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        @(negedge clk);
        check("rst_state", int'(game_state), 0);
        check("rst_x", int'(snake_x), 120);
        check("rst_y", int'(snake_y), 112);
        check("rst_dir", int'(dir), 0);
        check("rst_step", int'(step), 0);
        check("rst_crashed", int'(crashed), 0);
        reset = 1'b0;
        tick(1);

        // T1: idle frames do nothing
        frames(20);
        @(negedge clk);
        check("t1_state", int'(game_state), 0);
        check("t1_x", int'(snake_x), 120);
        check("t1_steps", n_steps, 0);
        tick(1);

        // T2: start, one step on the fifth frame
        press(8'h10);
        @(negedge clk);
        check("t2_state", int'(game_state), 1);
        tick(1);
        frames(4);
        check("t2_no_step_yet", n_steps, 0);
        check("t2_x_hold", int'(snake_x), 120);
        push(136, 112, 0);
        frames(1);
        check("t2_one_step", n_steps, 1);
        check("t2_x", int'(snake_x), 136);

        // T3: reversal request ignored
        press(8'h01);
        push(152, 112, 0);
        frames(5);
        check("t3_dir", int'(dir), 0);

        // T4: up then right within one step, then left accepted
        press(8'h04);
        press(8'h02);
        push(152, 96, 2);
        frames(5);
        check("t4_dir_up", int'(dir), 2);
        press(8'h01);
        push(136, 96, 1);
        frames(5);
        check("t4_dir_left", int'(dir), 1);
        check("t4_x", int'(snake_x), 136);

        // Reset mid-RUN at frame_cnt=3
        frames(3);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        check("mid_rst_state", int'(game_state), 0);
        check("mid_rst_x", int'(snake_x), 120);
        check("mid_rst_y", int'(snake_y), 112);
        check("mid_rst_dir", int'(dir), 0);
        reset = 1'b0;
        tick(1);

        // T5: run right to the wall
        press(8'h10);
        for (int i = 1; i <= 7; i++) begin
            push(120 + 16 * i, 112, 0);
            frames(5);
            if (i == 3) begin
                press(8'h10);
                check("t5_start_in_run", int'(game_state), 1);
            end
        end
        check("t5_x_edge", int'(snake_x), 232);
        steps_before = n_steps;
        frames(4);
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
        @(negedge clk);
        check("t5_state_dead", int'(game_state), 2);
        check("t5_crashed", int'(crashed), 1);
        check("t5_x_held", int'(snake_x), 232);
        check("t5_no_step", n_steps, steps_before);
        tick(1);
        press(8'h08);
        frames(5);
        check("dead_x", int'(snake_x), 232);
        check("dead_y", int'(snake_y), 112);
        check("dead_state", int'(game_state), 2);

        // T6: start edge from DEAD returns home
        press(8'h10);
        @(negedge clk);
        check("t6_state", int'(game_state), 0);
        check("t6_x", int'(snake_x), 120);
        check("t6_y", int'(snake_y), 112);
        check("t6_dir", int'(dir), 0);
        check("t6_crashed", int'(crashed), 0);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
